// File: rtl/dmem_port_ctrl.sv
// Single-outstanding load/store responder between the LSQ and the D-cache.
// Issues one cache access per request and returns a formatted, rob_id-tagged result.
module dmem_port_ctrl #(
    parameter int unsigned ROB_ID_SIZE = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ROB_ID_SIZE-1:0] req_rob_id,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    input  logic [3:0]             req_rmask,
    input  logic [3:0]             req_wmask,
    input  logic [2:0]             req_funct3,
    input  logic                   flush,
    output logic [31:0]            dmem_addr,
    output logic [3:0]             dmem_rmask,
    output logic [3:0]             dmem_wmask,
    output logic [31:0]            dmem_wdata,
    input  logic [31:0]            dmem_rdata,
    input  logic                   dmem_resp,
    output logic                   rob_ready,
    output logic [ROB_ID_SIZE-1:0] rob_id,
    output logic [31:0]            rob_rd_data,
    output logic [31:0]            rob_dmem_rdata,
    output logic                   rob_store
);

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_REQ,
        MEM_RESP_WAIT
    } mem_controller_states;

    mem_controller_states state, state_next;

    logic [ROB_ID_SIZE-1:0] rob_id_q;
    logic [31:0]            addr_q;
    logic [31:0]            wdata_q;
    logic [3:0]             rmask_q;
    logic [3:0]             wmask_q;
    logic [2:0]             funct3_q;
    logic                   kill_q;

    logic        is_load;
    logic        is_store;
    logic        no_access;
    logic        accept;
    logic        issue;
    logic        resp_done;
    logic        kill_now;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_fmt;

    always_comb begin
        is_load   = |rmask_q;
        is_store  = |wmask_q;
        no_access = ~is_load & ~is_store;
        accept    = (state == MEM_IDLE) & req_valid & ~flush;
        // A load flushed while in MEM_REQ never reaches the cache.
        issue     = (state == MEM_REQ) & ~no_access & ~(flush & is_load);
        resp_done = (state == MEM_RESP_WAIT) & dmem_resp;
        kill_now  = kill_q | (flush & is_load);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            MEM_IDLE:      if (accept) state_next = MEM_REQ;
            MEM_REQ:       state_next = issue ? MEM_RESP_WAIT : MEM_IDLE;
            MEM_RESP_WAIT: if (dmem_resp) state_next = MEM_IDLE;
            default:       state_next = MEM_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == MEM_IDLE);
        dmem_addr  = '0;
        dmem_rmask = '0;
        dmem_wmask = '0;
        dmem_wdata = '0;
        if (issue) begin
            dmem_addr  = {addr_q[31:2], 2'b00};
            dmem_rmask = rmask_q;
            dmem_wmask = wmask_q;
            dmem_wdata = wdata_q;
        end
    end

    always_comb begin
        sel_byte = '0;
        unique case (addr_q[1:0])
            2'd0: sel_byte = dmem_rdata[7:0];
            2'd1: sel_byte = dmem_rdata[15:8];
            2'd2: sel_byte = dmem_rdata[23:16];
            2'd3: sel_byte = dmem_rdata[31:24];
            default: sel_byte = '0;
        endcase
        sel_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        unique case (funct3_q)
            3'b000:  load_fmt = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_fmt = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_fmt = {24'd0, sel_byte};
            3'b101:  load_fmt = {16'd0, sel_half};
            default: load_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= MEM_IDLE;
            rob_id_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rmask_q  <= '0;
            wmask_q  <= '0;
            funct3_q <= '0;
            kill_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                rob_id_q <= req_rob_id;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                rmask_q  <= req_rmask;
                wmask_q  <= req_wmask;
                funct3_q <= req_funct3;
            end
            if (resp_done)
                kill_q <= 1'b0;
            else if ((state == MEM_RESP_WAIT) && flush && is_load)
                kill_q <= 1'b1;
        end
    end

    // Result bus is a one-cycle pulse; all fields return to zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rob_ready      <= 1'b0;
            rob_id         <= '0;
            rob_rd_data    <= '0;
            rob_dmem_rdata <= '0;
            rob_store      <= 1'b0;
        end else begin
            rob_ready      <= 1'b0;
            rob_id         <= '0;
            rob_rd_data    <= '0;
            rob_dmem_rdata <= '0;
            rob_store      <= 1'b0;
            if (accept && (req_rmask == 4'd0) && (req_wmask == 4'd0)) begin
                rob_ready <= 1'b1;
                rob_id    <= req_rob_id;
            end else if (resp_done && !kill_now) begin
                rob_ready      <= 1'b1;
                rob_id         <= rob_id_q;
                rob_rd_data    <= is_store ? 32'd0 : load_fmt;
                rob_dmem_rdata <= dmem_rdata;
                rob_store      <= is_store;
            end
        end
    end

endmodule
